// File: rtl/cms_pkg.sv
`default_nettype none
// ============================================================================
// cms_pkg -- state encoding, tag layout and width helpers for complex_mse_stream
// Rev 1.0
// ============================================================================
package cms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cms_state_e;

  localparam int LOG2_W = 3;

  // Travels alongside each sample so the accumulate stage knows block framing
  // and the shift amount, even when the next block has already latched a new N.
  typedef struct packed {
    logic              first;
    logic              last;
    logic [LOG2_W-1:0] n;
  } cms_tag_t;

  localparam int TAG_W = $bits(cms_tag_t);

  function automatic int diff_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int sq_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int acc_w(input int data_w, input int max_log2);
    return sq_w(data_w) + max_log2;
  endfunction

  function automatic int cnt_w(input int max_log2);
    return max_log2 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cms_sq_mag.sv
`default_nettype none
// ============================================================================
// cms_sq_mag -- 2-stage |y - y_hat|^2 with valid/tag passthrough
// Rev 1.0
// ============================================================================
module cms_sq_mag
  import cms_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W_P = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [TAG_W_P-1:0]    i_tag,
  input  logic [2*DATA_W-1:0]   i_y,
  input  logic [2*DATA_W-1:0]   i_y_hat,
  output logic                  o_valid,
  output logic [TAG_W_P-1:0]    o_tag,
  output logic [2*DATA_W:0]     o_sq
);

  localparam int DIFF_W = diff_w(DATA_W);
  localparam int SQ_W   = sq_w(DATA_W);

  logic signed [DIFF_W-1:0] d_re_d, d_im_d, d_re_q, d_im_q;
  logic signed [SQ_W-1:0]   re_x, im_x;
  logic        [SQ_W-1:0]   sq_d, sq_q;
  logic                     v1_q, v2_q;
  logic [TAG_W_P-1:0]       tag1_q, tag2_q;

  always_comb begin
    d_re_d = DIFF_W'($signed(i_y[2*DATA_W-1:DATA_W])) - DIFF_W'($signed(i_y_hat[2*DATA_W-1:DATA_W]));
    d_im_d = DIFF_W'($signed(i_y[DATA_W-1:0]))        - DIFF_W'($signed(i_y_hat[DATA_W-1:0]));
  end

  // The true sum of squares fits SQ_W unsigned, so wrapping SQ_W arithmetic is exact.
  always_comb begin
    re_x = SQ_W'(d_re_q);
    im_x = SQ_W'(d_im_q);
    sq_d = SQ_W'(re_x * re_x + im_x * im_x);
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      d_re_q <= '0;
      d_im_q <= '0;
      sq_q   <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      v1_q   <= i_valid & ~i_flush;
      v2_q   <= v1_q & ~i_flush;
      tag1_q <= i_flush ? '0 : i_tag;
      tag2_q <= i_flush ? '0 : tag1_q;
      if (i_valid) begin
        d_re_q <= d_re_d;
        d_im_q <= d_im_d;
      end
      if (v1_q) begin
        sq_q <= sq_d;
      end
    end
  end

  assign o_valid = v2_q;
  assign o_tag   = tag2_q;
  assign o_sq    = sq_q;

endmodule
`default_nettype wire

// File: rtl/complex_mse_stream.sv
`default_nettype none
// ============================================================================
// complex_mse_stream -- streaming block mean of |y - y_hat|^2 over 2^N samples
// Rev 1.0
// ============================================================================
module complex_mse_stream
  import cms_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_LOG2 = 7,
  parameter int ROUND    = 0
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [2:0]            i_log2_samples,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [2*DATA_W-1:0]   i_y,
  input  logic [2*DATA_W-1:0]   i_y_hat,
  output logic                  o_valid,
  output logic [2*DATA_W:0]     o_data
);

  localparam int SQ_W  = sq_w(DATA_W);
  localparam int ACC_W = acc_w(DATA_W, MAX_LOG2);
  localparam int CNT_W = cnt_w(MAX_LOG2);

  cms_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, blk_max;
  logic [LOG2_W-1:0]  n_q, n_d, n_clamped, n_blk;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_sum;
  logic [ACC_W:0]     bias;
  logic [SQ_W-1:0]    o_data_q, o_data_d, mean;
  logic               o_valid_q, o_valid_d;
  logic               accept, first, last;
  cms_tag_t           tag_in, tag_s3;
  logic [TAG_W-1:0]   tag_s3_raw;
  logic               sq_valid;
  logic [SQ_W-1:0]    sq;

  // N is taken live on the first sample of a block, held thereafter.
  always_comb begin
    n_clamped = (i_log2_samples > LOG2_W'(MAX_LOG2)) ? LOG2_W'(MAX_LOG2) : i_log2_samples;
    first     = (cnt_q == '0);
    n_blk     = first ? n_clamped : n_q;
    blk_max   = (CNT_W'(1) << n_blk) - CNT_W'(1);
    last      = (cnt_q == blk_max);
    o_ready   = (state_q == ST_RUN);
    accept    = i_en & i_valid & o_ready;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    case (state_q)
      ST_IDLE: begin
        if (i_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          n_d = n_blk;
          if (last) begin
            cnt_d = '0;
            if (!i_mode) state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (!i_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign tag_in = '{first: first, last: last, n: n_blk};

  cms_sq_mag #(
    .DATA_W  (DATA_W),
    .TAG_W_P (TAG_W)
  ) u_sq_mag (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_flush (~i_en),
    .i_valid (accept),
    .i_tag   (tag_in),
    .i_y     (i_y),
    .i_y_hat (i_y_hat),
    .o_valid (sq_valid),
    .o_tag   (tag_s3_raw),
    .o_sq    (sq)
  );

  assign tag_s3 = cms_tag_t'(tag_s3_raw);

  generate
    if (ROUND != 0) begin : g_round
      assign bias = ({{ACC_W{1'b0}}, 1'b1} << tag_s3.n) >> 1;
    end else begin : g_trunc
      assign bias = '0;
    end
  endgenerate

  always_comb begin
    acc_sum   = tag_s3.first ? ACC_W'(sq) : acc_q + ACC_W'(sq);
    mean      = SQ_W'(({1'b0, acc_sum} + bias) >> tag_s3.n);
    acc_d     = acc_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    if (sq_valid) begin
      acc_d = acc_sum;
      if (tag_s3.last) begin
        o_valid_d = 1'b1;
        o_data_d  = mean;
      end
    end
    if (!i_en) begin
      acc_d     = '0;
      o_valid_d = 1'b0;
      o_data_d  = o_data_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      acc_q     <= acc_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_mse_stream.sv
`default_nettype none
// ============================================================================
// tb_complex_mse_stream -- randomized self-checking bench with block-mean model
// Rev 1.0
// ============================================================================
module tb_complex_mse_stream;

  logic        clk = 1'b0;
  logic        arst, en, mode, valid;
  logic [2:0]  l2;
  logic [31:0] y, yh;
  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [32:0] dat0, dat1, dat2;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_acc = 0;
  longint q0[$], q1[$], q2[$], t0[$];

  complex_mse_stream #(.DATA_W(16), .MAX_LOG2(7), .ROUND(0)) dut0 (
    .i_clk(clk), .i_arst(arst), .i_en(en), .i_mode(mode), .i_log2_samples(l2),
    .i_valid(valid), .o_ready(rdy0), .i_y(y), .i_y_hat(yh), .o_valid(vld0), .o_data(dat0));
  complex_mse_stream #(.DATA_W(16), .MAX_LOG2(7), .ROUND(1)) dut1 (
    .i_clk(clk), .i_arst(arst), .i_en(en), .i_mode(mode), .i_log2_samples(l2),
    .i_valid(valid), .o_ready(rdy1), .i_y(y), .i_y_hat(yh), .o_valid(vld1), .o_data(dat1));
  complex_mse_stream #(.DATA_W(16), .MAX_LOG2(5), .ROUND(0)) dut2 (
    .i_clk(clk), .i_arst(arst), .i_en(en), .i_mode(mode), .i_log2_samples(l2),
    .i_valid(valid), .o_ready(rdy2), .i_y(y), .i_y_hat(yh), .o_valid(vld2), .o_data(dat2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld0) begin q0.push_back(longint'(dat0)); t0.push_back(cyc); end
    if (vld1) q1.push_back(longint'(dat1));
    if (vld2) q2.push_back(longint'(dat2));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: mean of |d|^2 over a block, from plain integer arithmetic.
  function automatic longint sqmag(input logic [31:0] a, input logic [31:0] b);
    longint re, im;
    re = longint'($signed(a[31:16])) - longint'($signed(b[31:16]));
    im = longint'($signed(a[15:0]))  - longint'($signed(b[15:0]));
    return re * re + im * im;
  endfunction

  function automatic longint mean_of(input longint acc, input int n, input bit rnd);
    if (rnd && n > 0) return (acc + (longint'(1) << (n - 1))) >>> n;
    return acc >>> n;
  endfunction

  function automatic logic [63:0] mkd(input int dre, input int dim);
    int yr, yi, hr, hi;
    yr = int'($urandom_range(40000)) - 20000;
    yi = int'($urandom_range(40000)) - 20000;
    hr = yr - dre;
    hi = yi - dim;
    return {yr[15:0], yi[15:0], hr[15:0], hi[15:0]};
  endfunction

  task automatic clear_q();
    q0.delete(); q1.delete(); q2.delete(); t0.delete();
  endtask

  task automatic restart();
    valid = 1'b0;
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic idle(input int k);
    valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ys, input logic [31:0] yhs, input int which);
    int guard;
    guard = 0;
    y = ys; yh = yhs; valid = 1'b1;
    while (!(which == 2 ? rdy2 : rdy0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      errors++; checks++;
      $display("FAIL send_timeout: ready never rose within %0d cycles", guard);
    end
    @(negedge clk);
    last_acc = cyc;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; en = 1'b0; mode = 1'b0; valid = 1'b0; l2 = 3'd0; y = '0; yh = '0;
    repeat (2) @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rdy0); end
    checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld0); end
    checks++; if (dat0 !== 33'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", dat0); end
    arst = 1'b0;
    @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", rdy0); end
  endtask

  task automatic test_oneshot();
    longint lastc;
    mode = 1'b0; l2 = 3'd3;
    restart(); clear_q();
    for (int i = 0; i < 8; i++) send(32'h0003_0004, 32'h0, 0);
    lastc = last_acc;
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL oneshot_done_ready: got %b expected 0", rdy0); end
    drain();
    checks++; if (q0.size() != 1 || q0[0] !== 64'd25) begin errors++; $display("FAIL oneshot_mean: count %0d first %0d expected one of 25", q0.size(), (q0.size() > 0) ? q0[0] : -1); end
    checks++; if (t0.size() != 1 || t0[0] - lastc !== 64'd2) begin errors++; $display("FAIL oneshot_latency: got %0d edges expected 2", (t0.size() > 0) ? t0[0] - lastc : -1); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL oneshot_hold_ready: got %b expected 0", rdy0); end
    en = 1'b0; @(negedge clk);
    en = 1'b1; @(negedge clk);
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reenable_ready: got %b expected 1", rdy0); end
  endtask

  task automatic test_random_oneshot();
    longint acc;
    int n;
    logic [31:0] a, b;
    mode = 1'b0;
    for (int rep = 0; rep < 4; rep++) begin
      n = int'($urandom_range(3));
      l2 = 3'(n);
      restart(); clear_q();
      acc = 0;
      for (int i = 0; i < (1 << n); i++) begin
        a = $urandom; b = $urandom;
        acc += sqmag(a, b);
        send(a, b, 0);
      end
      drain();
      checks++; if (q0.size() != 1 || q0[0] !== mean_of(acc, n, 0)) begin errors++; $display("FAIL rand_trunc n=%0d: got %0d expected %0d", n, (q0.size() > 0) ? q0[0] : -1, mean_of(acc, n, 0)); end
      checks++; if (q1.size() != 1 || q1[0] !== mean_of(acc, n, 1)) begin errors++; $display("FAIL rand_round n=%0d: got %0d expected %0d", n, (q1.size() > 0) ? q1[0] : -1, mean_of(acc, n, 1)); end
      checks++; if (q2.size() != 1 || q2[0] !== mean_of(acc, n, 0)) begin errors++; $display("FAIL rand_max5 n=%0d: got %0d expected %0d", n, (q2.size() > 0) ? q2[0] : -1, mean_of(acc, n, 0)); end
    end
  endtask

  task automatic test_extreme();
    mode = 1'b0; l2 = 3'd0;
    restart(); clear_q();
    send(32'h8000_8000, 32'h7FFF_7FFF, 0);
    drain();
    checks++; if (q0.size() != 1 || q0[0] !== 64'd8589672450) begin errors++; $display("FAIL extreme_trunc: got %0d expected 8589672450", (q0.size() > 0) ? q0[0] : -1); end
    checks++; if (q1.size() != 1 || q1[0] !== 64'd8589672450) begin errors++; $display("FAIL extreme_round: got %0d expected 8589672450", (q1.size() > 0) ? q1[0] : -1); end
  endtask

  task automatic test_round();
    logic [63:0] p;
    mode = 1'b0; l2 = 3'd1;
    restart(); clear_q();
    p = mkd(1, 0); send(p[63:32], p[31:0], 0);
    p = mkd(1, 1); send(p[63:32], p[31:0], 0);
    drain();
    checks++; if (q0.size() != 1 || q0[0] !== 64'd1) begin errors++; $display("FAIL round0_mean: got %0d expected 1", (q0.size() > 0) ? q0[0] : -1); end
    checks++; if (q1.size() != 1 || q1[0] !== 64'd2) begin errors++; $display("FAIL round1_mean: got %0d expected 2", (q1.size() > 0) ? q1[0] : -1); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] p;
    bit ok;
    longint exp0[$], exp1[$], acc;
    int n, len;
    logic [31:0] a, b;
    mode = 1'b1; l2 = 3'd2;
    restart(); clear_q();
    ok = 1'b1;
    for (int blk = 1; blk <= 3; blk++) begin
      for (int i = 0; i < 4; i++) begin
        p = mkd(blk, 0);
        send(p[63:32], p[31:0], 0);
        if (rdy0 !== 1'b1) ok = 1'b0;
      end
    end
    drain();
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1 throughout", ok); end
    checks++; if (q0.size() != 3 || q0[0] !== 64'd1 || q0[1] !== 64'd4 || q0[2] !== 64'd9) begin errors++; $display("FAIL b2b_means: count %0d expected 1,4,9", q0.size()); end
    checks++; if (t0.size() != 3 || t0[1] - t0[0] !== 64'd4 || t0[2] - t0[1] !== 64'd4) begin errors++; $display("FAIL b2b_spacing: count %0d expected pulses 4 cycles apart", t0.size()); end

    // Random continuous blocks with stalls and ignored mid-block size changes.
    restart(); clear_q();
    for (int blk = 0; blk < 4; blk++) begin
      n = int'($urandom_range(3));
      len = 1 << n;
      l2 = 3'(n);
      acc = 0;
      for (int i = 0; i < len; i++) begin
        a = $urandom; b = $urandom;
        acc += sqmag(a, b);
        send(a, b, 0);
        l2 = 3'($urandom_range(7));
        if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 2)));
      end
      exp0.push_back(mean_of(acc, n, 0));
      exp1.push_back(mean_of(acc, n, 1));
    end
    drain();
    checks++; if (q0.size() != exp0.size() || q1.size() != exp1.size()) begin errors++; $display("FAIL cont_count: got %0d/%0d expected %0d", q0.size(), q1.size(), exp0.size()); end
    else begin
      for (int i = 0; i < exp0.size(); i++) begin
        checks++; if (q0[i] !== exp0[i]) begin errors++; $display("FAIL cont_trunc[%0d]: got %0d expected %0d", i, q0[i], exp0[i]); end
        checks++; if (q1[i] !== exp1[i]) begin errors++; $display("FAIL cont_round[%0d]: got %0d expected %0d", i, q1[i], exp1[i]); end
      end
    end
  endtask

  task automatic test_abort(input bit gaps);
    logic [63:0] p;
    logic [31:0] a, b;
    mode = 1'b0; l2 = 3'd3;
    restart(); clear_q();
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom;
      send(a, b, 0);
      if (gaps && i == 2) idle(2);
    end
    en = 1'b0; @(negedge clk);
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", rdy0); end
    en = 1'b1; @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      p = mkd(0, 2);
      send(p[63:32], p[31:0], 0);
      if (gaps && (i % 3 == 1)) idle(int'($urandom_range(1, 3)));
    end
    drain();
    checks++; if (q0.size() != 1 || q0[0] !== 64'd4) begin errors++; $display("FAIL abort_mean gaps=%0d: count %0d first %0d expected one of 4", gaps, q0.size(), (q0.size() > 0) ? q0[0] : -1); end
  endtask

  task automatic test_clamp();
    longint acc;
    logic [31:0] a, b;
    mode = 1'b0; l2 = 3'd7;
    restart(); clear_q();
    acc = 0;
    for (int i = 0; i < 32; i++) begin
      a = $urandom; b = $urandom;
      acc += sqmag(a, b);
      send(a, b, 2);
      if (i == 2) l2 = 3'd1;
    end
    drain();
    checks++; if (q2.size() != 1 || q2[0] !== mean_of(acc, 5, 0)) begin errors++; $display("FAIL clamp_mean: count %0d first %0d expected %0d", q2.size(), (q2.size() > 0) ? q2[0] : -1, mean_of(acc, 5, 0)); end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL clamp_max7_early: got %0d outputs expected 0", q0.size()); end
    checks++; if (rdy2 !== 1'b0) begin errors++; $display("FAIL clamp_done_ready: got %b expected 0", rdy2); end
    restart(); clear_q();
    acc = 0;
    for (int i = 0; i < 2; i++) begin
      a = $urandom; b = $urandom;
      acc += sqmag(a, b);
      send(a, b, 2);
    end
    drain();
    checks++; if (q2.size() != 1 || q2[0] !== mean_of(acc, 1, 0)) begin errors++; $display("FAIL clamp_next_block: got %0d expected %0d", (q2.size() > 0) ? q2[0] : -1, mean_of(acc, 1, 0)); end
    checks++; if (q0.size() != 1 || q0[0] !== mean_of(acc, 1, 0)) begin errors++; $display("FAIL clamp_next_max7: got %0d expected %0d", (q0.size() > 0) ? q0[0] : -1, mean_of(acc, 1, 0)); end
  endtask

  task automatic test_async_reset();
    logic [63:0] p;
    mode = 1'b0; l2 = 3'd2;
    restart(); clear_q();
    for (int i = 0; i < 2; i++) begin
      p = mkd(7, 3);
      send(p[63:32], p[31:0], 0);
    end
    #2 arst = 1'b1;
    #1;
    checks++; if (rdy0 !== 1'b0 || vld0 !== 1'b0 || dat0 !== 33'd0) begin errors++; $display("FAIL async_reset: ready %b valid %b data %0d expected 0/0/0", rdy0, vld0, dat0); end
    @(negedge clk);
    arst = 1'b0;
    restart(); clear_q();
    for (int i = 0; i < 4; i++) begin
      p = mkd(2, 1);
      send(p[63:32], p[31:0], 0);
    end
    drain();
    checks++; if (q0.size() != 1 || q0[0] !== 64'd5) begin errors++; $display("FAIL post_reset_mean: got %0d expected 5", (q0.size() > 0) ? q0[0] : -1); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_random_oneshot();
    test_extreme();
    test_round();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    test_clamp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
